// File: rtl/fxp_div_pipe_if.sv
// Operand/result bundle for the streaming fixed-point divider.
//
// Signals:
//   dividend  WIIA+WIFA bits, signed fixed-point numerator
//   divisor   WIIB+WIFB bits, signed fixed-point denominator
//   out       WOI+WOF bits, signed fixed-point quotient (registered in the divider)
//   overflow  quotient saturated (range overflow or divide by zero)
//
// Modports:
//   master  the producer of operands / consumer of results
//   slave   the divider itself
interface fxp_div_pipe_if #(
    parameter int WIIA = 8,
    parameter int WIFA = 8,
    parameter int WIIB = 8,
    parameter int WIFB = 8,
    parameter int WOI  = 8,
    parameter int WOF  = 8
) ();
    logic [WIIA+WIFA-1:0] dividend;
    logic [WIIB+WIFB-1:0] divisor;
    logic [WOI+WOF-1:0]   out;
    logic                 overflow;

    modport master (output dividend, output divisor, input out, input overflow);
    modport slave  (input dividend, input divisor, output out, output overflow);
endinterface

// File: rtl/fxp_div_pipe.sv
// Fully pipelined signed fixed-point divider.
//
// Accepts one dividend/divisor pair every clock and returns the saturated,
// optionally rounded quotient WOI+WOF+3 cycles later. No handshaking.
//
// Ports:
//   clk   single clock, rising edge
//   rstn  asynchronous reset, ACTIVE HIGH (1 = reset) despite the name
//   bus   fxp_div_pipe_if.slave: dividend/divisor in, out/overflow out
//
// Pipeline:
//   stage 0        sign, |A|, |B|, divide-by-zero flag
//   WOI+WOF+1      restoring shift-subtract stages, one quotient bit each,
//                  MSB first; the last bit is a guard bit for rounding
//   output stage   round, apply sign, saturate
module fxp_div_pipe #(
    parameter int WIIA  = 8,
    parameter int WIFA  = 8,
    parameter int WIIB  = 8,
    parameter int WIFB  = 8,
    parameter int WOI   = 8,
    parameter int WOF   = 8,
    parameter bit ROUND = 1'b1
) (
    input  logic           clk,
    input  logic           rstn,
    fxp_div_pipe_if.slave  bus
);
    localparam int WA = WIIA + WIFA;
    localparam int WB = WIIB + WIFB;
    localparam int WO = WOI + WOF;
    localparam int NQ = WO + 1;                  // quotient bits incl. guard bit
    localparam int SH = WIFB - WIFA + WOF + 1;   // numerator alignment
    localparam int NW = (SH > 0) ? WA + SH : WA; // aligned numerator width
    localparam int RW = WB + 1;                  // trial remainder width
    localparam int CW = ((NW > WB) ? NW : WB) + 1;

    localparam logic [NQ-1:0] POS_LIM = {2'b00, {(WO-1){1'b1}}};
    localparam logic [NQ-1:0] NEG_LIM = {2'b01, {(WO-1){1'b0}}};
    localparam logic [WO-1:0] OUT_MAX = {1'b0, {(WO-1){1'b1}}};
    localparam logic [WO-1:0] OUT_MIN = {1'b1, {(WO-1){1'b0}}};
    localparam logic [NQ:0]   RND_INC = ROUND ? (NQ+1)'(1) : '0;

    // ------------------------------------------------------------------
    // Stage 0: magnitudes and sign
    // ------------------------------------------------------------------
    logic [WA-1:0] absa_next;
    logic [WB-1:0] absb_next;
    logic [WA-1:0] s0_absa_reg;
    logic [WB-1:0] s0_absb_reg;
    logic          s0_sign_reg;
    logic          s0_dz_reg;

    // WA bits unsigned hold the magnitude of the most negative code.
    assign absa_next = bus.dividend[WA-1] ? (~bus.dividend) + WA'(1) : bus.dividend;
    assign absb_next = bus.divisor[WB-1]  ? (~bus.divisor)  + WB'(1) : bus.divisor;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            s0_absa_reg <= '0;
            s0_absb_reg <= '0;
            s0_sign_reg <= 1'b0;
            s0_dz_reg   <= 1'b0;
        end else begin
            s0_absa_reg <= absa_next;
            s0_absb_reg <= absb_next;
            s0_sign_reg <= bus.dividend[WA-1] ^ bus.divisor[WB-1];
            s0_dz_reg   <= (bus.divisor == '0);
        end
    end

    // Aligned numerator N so that floor(N/|B|) is the quotient with one
    // guard bit below the output LSB.
    logic [NW-1:0] num0;
    if (SH >= 0) begin : g_shl
        assign num0 = NW'(s0_absa_reg) << SH;
    end else begin : g_shr
        assign num0 = NW'(s0_absa_reg >> (-SH));
    end

    // Bits of N above the quotient window: if they alone are >= |B| the
    // quotient has a set bit above the window, i.e. it cannot be represented.
    // A zero divisor never reports sticky here; a cleared stage 0 (after
    // reset) therefore flows through as a plain zero result, and a real
    // divide by zero is handled by the dz flag in the output stage.
    logic [CW-1:0] hi_ext;
    logic [CW-1:0] den_ext;
    logic          sticky0;
    logic [WB-1:0] rem0;
    logic [NQ-1:0] low0;

    assign hi_ext  = CW'(num0 >> NQ);
    assign den_ext = CW'(s0_absb_reg);
    assign sticky0 = (s0_absb_reg != '0) && (hi_ext >= den_ext);
    assign rem0    = sticky0 ? '0 : hi_ext[WB-1:0];
    assign low0    = NQ'(num0);

    // ------------------------------------------------------------------
    // Quotient stages: stage gi produces quotient bit NQ-1-gi
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NQ; gi++) begin : g_stage
        localparam int BIT = NQ - 1 - gi;

        // Only the numerator bits not yet consumed travel down the pipe.
        logic [BIT:0]   low_in;
        logic [WB-1:0]  den_in;
        logic [WB-1:0]  rem_in;
        logic [NQ-1:0]  quo_in;
        logic           sign_in;
        logic           dz_in;
        logic           sticky_in;

        logic [RW-1:0]  trial;
        logic           ge;
        logic [NQ-1:0]  quo_reg;
        logic           sign_reg;
        logic           dz_reg;
        logic           sticky_reg;

        if (gi == 0) begin : g_src
            assign low_in    = low0;
            assign den_in    = s0_absb_reg;
            assign rem_in    = rem0;
            assign quo_in    = '0;
            assign sign_in   = s0_sign_reg;
            assign dz_in     = s0_dz_reg;
            assign sticky_in = sticky0;
        end else begin : g_src
            assign low_in    = g_stage[gi-1].g_carry.low_reg;
            assign den_in    = g_stage[gi-1].g_carry.den_reg;
            assign rem_in    = g_stage[gi-1].g_carry.rem_reg;
            assign quo_in    = g_stage[gi-1].quo_reg;
            assign sign_in   = g_stage[gi-1].sign_reg;
            assign dz_in     = g_stage[gi-1].dz_reg;
            assign sticky_in = g_stage[gi-1].sticky_reg;
        end

        // Remainder stays below |B|, so it fits WB bits before the shift.
        assign trial = {rem_in, low_in[BIT]};
        assign ge    = (den_in != '0) && (trial >= {1'b0, den_in});

        always_ff @(posedge clk or posedge rstn) begin
            if (rstn) begin
                quo_reg    <= '0;
                sign_reg   <= 1'b0;
                dz_reg     <= 1'b0;
                sticky_reg <= 1'b0;
            end else begin
                quo_reg    <= quo_in | (NQ'(ge) << BIT);
                sign_reg   <= sign_in;
                dz_reg     <= dz_in;
                sticky_reg <= sticky_in;
            end
        end

        // Remainder, divisor and remaining numerator bits are only needed
        // by a following quotient stage.
        if (gi < NQ - 1) begin : g_carry
            logic [BIT-1:0] low_reg;
            logic [WB-1:0]  den_reg;
            logic [WB-1:0]  rem_reg;
            logic [WB-1:0]  rem_next;

            assign rem_next = ge ? WB'(trial - {1'b0, den_in}) : trial[WB-1:0];

            always_ff @(posedge clk or posedge rstn) begin
                if (rstn) begin
                    low_reg <= '0;
                    den_reg <= '0;
                    rem_reg <= '0;
                end else begin
                    low_reg <= low_in[BIT-1:0];
                    den_reg <= den_in;
                    rem_reg <= rem_next;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage: round, sign, saturate
    // ------------------------------------------------------------------
    logic [NQ-1:0] m_fin;
    logic          sign_fin;
    logic          dz_fin;
    logic          sticky_fin;
    logic [NQ:0]   m_sum;
    logic [NQ-1:0] mag;
    logic [WO-1:0] out_next;
    logic          ovf_next;
    logic [WO-1:0] out_reg;
    logic          ovf_reg;

    assign m_fin      = g_stage[NQ-1].quo_reg;
    assign sign_fin   = g_stage[NQ-1].sign_reg;
    assign dz_fin     = g_stage[NQ-1].dz_reg;
    assign sticky_fin = g_stage[NQ-1].sticky_reg;

    // Adding one at the guard bit then dropping it rounds half away from
    // zero on the magnitude; without it the drop truncates toward zero.
    assign m_sum = {1'b0, m_fin} + RND_INC;
    assign mag   = NQ'(m_sum >> 1);

    always_comb begin
        out_next = '0;
        ovf_next = 1'b0;
        if (dz_fin) begin
            // With a zero divisor the sign flag equals the dividend's sign.
            out_next = sign_fin ? OUT_MIN : OUT_MAX;
            ovf_next = 1'b1;
        end else if (!sign_fin) begin
            if (sticky_fin || (mag > POS_LIM)) begin
                out_next = OUT_MAX;
                ovf_next = 1'b1;
            end else begin
                out_next = mag[WO-1:0];
            end
        end else begin
            if (sticky_fin || (mag > NEG_LIM)) begin
                out_next = OUT_MIN;
                ovf_next = 1'b1;
            end else begin
                out_next = WO'(NQ'(0) - mag);
            end
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            out_reg <= '0;
            ovf_reg <= 1'b0;
        end else begin
            out_reg <= out_next;
            ovf_reg <= ovf_next;
        end
    end

    assign bus.out      = out_reg;
    assign bus.overflow = ovf_reg;
endmodule

// File: tb/tb_fxp_div_pipe.sv
// Self-checking bench for fxp_div_pipe in its default 8.8 / 8.8 -> 8.8 format.
// Two instances run side by side on identical operands, one rounding and
// one truncating. Every sampled operand pair is logged; each cycle the
// outputs are compared with an arithmetic model of the operand pair that
// entered L-1 edges earlier (or zero where reset discarded it).
module tb_fxp_div_pipe;
    localparam int L  = 19;
    localparam int NE = 4096;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    fxp_div_pipe_if bus_r1 ();
    fxp_div_pipe_if bus_r0 ();

    fxp_div_pipe #(.ROUND(1'b1)) dut_r1 (.clk(clk), .rstn(rstn), .bus(bus_r1));
    fxp_div_pipe #(.ROUND(1'b0)) dut_r0 (.clk(clk), .rstn(rstn), .bus(bus_r0));

    int checks    = 0;
    int failures  = 0;
    int edge_cnt  = 0;
    int kill_upto = -1;
    logic [15:0] hist_a [0:NE-1];
    logic [15:0] hist_b [0:NE-1];

    // Quotient from the arithmetic definition: |A|*2^9/|B| is the quotient
    // in units of half an output LSB (2^(WOF+1+WIFB-WIFA) = 2^9).
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input bit rnd, output logic [15:0] o,
                                  output logic ov);
        longint sa, sb, na, nb, q, mag;
        bit neg;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            ov = 1'b1;
            o  = (sa < 0) ? 16'h8000 : 16'h7FFF;
            return;
        end
        na  = (sa < 0) ? -sa : sa;
        nb  = (sb < 0) ? -sb : sb;
        q   = (na * 512) / nb;
        mag = rnd ? (q + 1) / 2 : q / 2;
        neg = (sa < 0) != (sb < 0);
        if (!neg && mag > 32767) begin
            o = 16'h7FFF; ov = 1'b1;
        end else if (neg && mag > 32768) begin
            o = 16'h8000; ov = 1'b1;
        end else begin
            o  = 16'(neg ? -mag : mag);
            ov = 1'b0;
        end
    endfunction

    // Log the operand pair sampled at each rising edge.
    always @(posedge clk) begin
        hist_a[edge_cnt % NE] = bus_r1.dividend;
        hist_b[edge_cnt % NE] = bus_r1.divisor;
        if (rstn) kill_upto = edge_cnt;
        edge_cnt = edge_cnt + 1;
    end

    // Compare both instances every cycle, half a period after the edge.
    always @(negedge clk) begin
        int m, s;
        logic [15:0] e1, e0;
        logic v1, v0;
        m = edge_cnt - 1;
        s = m - (L - 1);
        if (rstn || s < 0 || s <= kill_upto) begin
            e1 = '0; v1 = 1'b0; e0 = '0; v0 = 1'b0;
        end else begin
            model(hist_a[s % NE], hist_b[s % NE], 1'b1, e1, v1);
            model(hist_a[s % NE], hist_b[s % NE], 1'b0, e0, v0);
        end
        checks = checks + 2;
        if (bus_r1.out !== e1 || bus_r1.overflow !== v1) begin
            failures = failures + 1;
            $display("FAIL cmp_round edge=%0d got out=%h ov=%b want out=%h ov=%b",
                     m, bus_r1.out, bus_r1.overflow, e1, v1);
        end
        if (bus_r0.out !== e0 || bus_r0.overflow !== v0) begin
            failures = failures + 1;
            $display("FAIL cmp_trunc edge=%0d got out=%h ov=%b want out=%h ov=%b",
                     m, bus_r0.out, bus_r0.overflow, e0, v0);
        end
    end

    task automatic step(input logic [15:0] a, input logic [15:0] b);
        @(posedge clk);
        #2;
        bus_r1.dividend = a;
        bus_r1.divisor  = b;
        bus_r0.dividend = a;
        bus_r0.divisor  = b;
    endtask

    task automatic check_zero(input string name);
        checks = checks + 1;
        if (bus_r1.out !== 16'h0000 || bus_r1.overflow !== 1'b0 ||
            bus_r0.out !== 16'h0000 || bus_r0.overflow !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL %s got r1=%h/%b r0=%h/%b want 0000/0", name,
                     bus_r1.out, bus_r1.overflow, bus_r0.out, bus_r0.overflow);
        end
    endtask

    // Hand-computed expectations: dividend, divisor, round, out, overflow.
    logic [15:0] pin_a   [0:15] = '{16'h0080, 16'hFE80, 16'h0080, 16'hFC80, 16'hFE80,
                                    16'hFE80, 16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF,
                                    16'h7F00, 16'h8000, 16'h8000, 16'h0100, 16'hFF00,
                                    16'h0000};
    logic [15:0] pin_b   [0:15] = '{16'h0180, 16'hFC80, 16'h0080, 16'hFC80, 16'h0180,
                                    16'hFC80, 16'h0200, 16'h0200, 16'h0200, 16'h0200,
                                    16'h0080, 16'hFF00, 16'h0100, 16'h0000, 16'h0000,
                                    16'h0000};
    bit          pin_r   [0:15] = '{1, 1, 1, 1, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1, 1, 1};
    logic [15:0] pin_o   [0:15] = '{16'h0055, 16'h006E, 16'h0100, 16'h0100, 16'hFF00,
                                    16'h006D, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000,
                                    16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000,
                                    16'h7FFF};
    bit          pin_v   [0:15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1};

    initial begin
        logic [15:0] mo, ra, rb;
        logic mv;

        bus_r1.dividend = '0; bus_r1.divisor = '0;
        bus_r0.dividend = '0; bus_r0.divisor = '0;

        // Pin the model to hand-derived values.
        for (int i = 0; i < 16; i++) begin
            model(pin_a[i], pin_b[i], pin_r[i], mo, mv);
            checks = checks + 1;
            if (mo !== pin_o[i] || mv !== pin_v[i]) begin
                failures = failures + 1;
                $display("FAIL model_pin[%0d] got %h/%b want %h/%b",
                         i, mo, mv, pin_o[i], pin_v[i]);
            end
        end

        // Power-on reset.
        #1;
        check_zero("reset_initial");
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b0;

        // Directed stream, back to back, then overflow and zero-divisor cases.
        for (int i = 0; i < 16; i++) step(pin_a[i], pin_b[i]);
        for (int i = 0; i < L + 2; i++) step(16'h0000, 16'h0100);

        // Reset in the middle of a stream.
        for (int i = 0; i < 10; i++) step(16'($urandom), 16'($urandom_range(1, 16'h0400)));
        @(posedge clk);
        #2;
        rstn = 1'b1;
        #1;
        check_zero("reset_midstream");
        for (int i = 0; i < 3; i++) step(16'($urandom), 16'($urandom));
        @(posedge clk);
        #2;
        rstn = 1'b0;

        // Randomized stream with a mix of operand classes.
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = 16'($urandom);
                1: rb = 16'($urandom_range(1, 16'h03FF));
                2: rb = 16'(-$urandom_range(1, 16'h03FF));
                default: begin
                    case ($urandom_range(0, 4))
                        0: rb = 16'h8000;
                        1: rb = 16'h7FFF;
                        2: rb = 16'h0001;
                        3: rb = 16'hFFFF;
                        default: rb = 16'h0000;
                    endcase
                    if ($urandom_range(0, 1) == 1) ra = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
                end
            endcase
            step(ra, rb);
        end

        // Flush with zero divisors, then drain the pipe.
        for (int i = 0; i < L + 5; i++) step(16'($urandom), 16'h0000);
        for (int i = 0; i < L + 2; i++) step(16'h0000, 16'h0100);
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
